// File: rtl/datapath_p2_pkg.sv
// rtl/datapath_p2_pkg.sv - shared encodings and IR field positions for datapath_p2
package datapath_p2_pkg;

   localparam int DW     = 32;
   localparam int NREG   = 16;
   localparam int RA_LSB = 23;
   localparam int RB_LSB = 19;
   localparam int RC_LSB = 15;
   localparam int C2_LSB = 19;
   localparam int C_W    = 19;

   typedef enum logic [3:0] {
      SRC_NONE, SRC_PC, SRC_ZHI, SRC_ZLO, SRC_MDR,
      SRC_HI, SRC_LO, SRC_INPORT, SRC_RF, SRC_C
   } bus_src_e;

   typedef enum logic [2:0] {
      ALU_PASS, ALU_INC, ALU_ADD, ALU_SUB, ALU_AND
   } alu_op_e;

   function automatic logic [DW-1:0] sext_c(input logic [DW-1:0] ir);
      return {{(DW-C_W){ir[C_W-1]}}, ir[C_W-1:0]};
   endfunction

endpackage

// File: rtl/datapath_p2_reg32.sv
// rtl/datapath_p2_reg32.sv - 32-bit load-enabled register with async active-low clear
module datapath_p2_reg32
   import datapath_p2_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   logic [DW-1:0] q_q;
   logic [DW-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (ld) q_d = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/datapath_p2.sv
// rtl/datapath_p2.sv - single-bus 32-bit CPU datapath with register file, ALU and CON flop
module datapath_p2
   import datapath_p2_pkg::*;
(
   input  logic          Clock,
   input  logic          Clear,
   output logic [DW-1:0] outp,
   output logic          BranchMet,
   input  logic          PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout,
   input  logic          MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
   input  logic          IncPC,
   input  logic          Read,
   input  logic          Write,
   input  logic          Cin,
   input  logic          Gra, Grb, Grc,
   input  logic          Rin, Rout,
   input  logic          BAout,
   input  logic          Cout,
   input  logic          CONIn,
   input  logic          Strobe,
   input  logic [DW-1:0] Mdatain,
   input  logic [DW-1:0] InPort_data,
   input  logic          SUB, AND, ADD
);

   logic [DW-1:0] bus;
   logic [DW-1:0] alu_res;
   logic [DW-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q, hi_q, lo_q, inport_q, outport_q;
   logic [DW-1:0] rf_q [NREG];
   logic [DW-1:0] rf_drive, c_val, mdr_d;
   logic [3:0]    rsel;
   bus_src_e      bus_src;
   alu_op_e       alu_op;
   logic          con_q, con_d, cond;
   logic          unused_bits;

   assign rsel = ({4{Gra}} & ir_q[RA_LSB +: 4])
               | ({4{Grb}} & ir_q[RB_LSB +: 4])
               | ({4{Grc}} & ir_q[RC_LSB +: 4]);

   assign c_val    = sext_c(ir_q);
   assign rf_drive = (BAout && rsel == 4'd0) ? '0 : rf_q[rsel];
   assign mdr_d    = Read ? Mdatain : bus;

   always_comb begin
      bus_src = SRC_NONE;
      if      (PCout)          bus_src = SRC_PC;
      else if (Zhiout)         bus_src = SRC_ZHI;
      else if (Zlowout)        bus_src = SRC_ZLO;
      else if (MDRout)         bus_src = SRC_MDR;
      else if (HIout)          bus_src = SRC_HI;
      else if (LOout)          bus_src = SRC_LO;
      else if (InPortout)      bus_src = SRC_INPORT;
      else if (Rout || BAout)  bus_src = SRC_RF;
      else if (Cout)           bus_src = SRC_C;
   end

   always_comb begin
      bus = '0;
      case (bus_src)
         SRC_PC:     bus = pc_q;
         SRC_ZHI:    bus = zhi_q;
         SRC_ZLO:    bus = zlo_q;
         SRC_MDR:    bus = mdr_q;
         SRC_HI:     bus = hi_q;
         SRC_LO:     bus = lo_q;
         SRC_INPORT: bus = inport_q;
         SRC_RF:     bus = rf_drive;
         SRC_C:      bus = c_val;
         default:    bus = '0;
      endcase
   end

   always_comb begin
      alu_op = ALU_PASS;
      if      (IncPC) alu_op = ALU_INC;
      else if (ADD)   alu_op = ALU_ADD;
      else if (SUB)   alu_op = ALU_SUB;
      else if (AND)   alu_op = ALU_AND;
   end

   // Results wrap modulo 2^32; the upper Z half is architecturally always zero.
   always_comb begin
      alu_res = bus;
      case (alu_op)
         ALU_INC: alu_res = bus + 32'd1;
         ALU_ADD: alu_res = y_q + bus + {{(DW-1){1'b0}}, Cin};
         ALU_SUB: alu_res = y_q - bus;
         ALU_AND: alu_res = y_q & bus;
         default: alu_res = bus;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (ir_q[C2_LSB +: 2])
         2'b00: cond = (bus == '0);
         2'b01: cond = (bus != '0);
         2'b10: cond = ~bus[DW-1];
         2'b11: cond =  bus[DW-1];
         default: cond = 1'b0;
      endcase
      con_d = con_q;
      if (CONIn) con_d = cond;
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) con_q <= 1'b0;
      else        con_q <= con_d;
   end

   datapath_p2_reg32 u_pc  (.clk(Clock), .rst_n(Clear), .ld(PCin),      .d(bus),         .q(pc_q));
   datapath_p2_reg32 u_ir  (.clk(Clock), .rst_n(Clear), .ld(IRin),      .d(bus),         .q(ir_q));
   datapath_p2_reg32 u_mar (.clk(Clock), .rst_n(Clear), .ld(MARin),     .d(bus),         .q(mar_q));
   datapath_p2_reg32 u_mdr (.clk(Clock), .rst_n(Clear), .ld(MDRin),     .d(mdr_d),       .q(mdr_q));
   datapath_p2_reg32 u_y   (.clk(Clock), .rst_n(Clear), .ld(Yin),       .d(bus),         .q(y_q));
   datapath_p2_reg32 u_zhi (.clk(Clock), .rst_n(Clear), .ld(Zin),       .d('0),          .q(zhi_q));
   datapath_p2_reg32 u_zlo (.clk(Clock), .rst_n(Clear), .ld(Zin),       .d(alu_res),     .q(zlo_q));
   datapath_p2_reg32 u_hi  (.clk(Clock), .rst_n(Clear), .ld(HIin),      .d(bus),         .q(hi_q));
   datapath_p2_reg32 u_lo  (.clk(Clock), .rst_n(Clear), .ld(LOin),      .d(bus),         .q(lo_q));
   datapath_p2_reg32 u_in  (.clk(Clock), .rst_n(Clear), .ld(Strobe),    .d(InPort_data), .q(inport_q));
   datapath_p2_reg32 u_out (.clk(Clock), .rst_n(Clear), .ld(OutPortin), .d(bus),         .q(outport_q));

   for (genvar i = 0; i < NREG; i++) begin : g_rf
      datapath_p2_reg32 u_r (.clk(Clock), .rst_n(Clear), .ld(Rin && (rsel == 4'(i))),
                             .d(bus), .q(rf_q[i]));
   end

   assign outp      = outport_q;
   assign BranchMet = con_q;

   // MAR and the memory write strobe feed external memory only.
   assign unused_bits = ^{Write, mar_q, ir_q[31:27]};

endmodule

// File: tb/tb_datapath_p2.sv
// tb/tb_datapath_p2.sv - scoreboard bench for datapath_p2 with a behavioural model
module tb_datapath_p2;

   logic        Clock = 1'b0;
   logic        Clear = 1'b0;
   logic [31:0] outp;
   logic        BranchMet;
   logic PCout = 0, Zhiout = 0, Zlowout = 0, MDRout = 0, HIout = 0, LOout = 0, InPortout = 0;
   logic MARin = 0, Zin = 0, PCin = 0, MDRin = 0, IRin = 0, Yin = 0, HIin = 0, LOin = 0, OutPortin = 0;
   logic IncPC = 0, Read = 0, Write = 0, Cin = 0, Gra = 0, Grb = 0, Grc = 0;
   logic Rin = 0, Rout = 0, BAout = 0, Cout = 0, CONIn = 0, Strobe = 0;
   logic SUB = 0, AND = 0, ADD = 0;
   logic [31:0] Mdatain = 0, InPort_data = 0;

   always #5 Clock = ~Clock;

   datapath_p2 dut (
      .Clock(Clock), .Clear(Clear), .outp(outp), .BranchMet(BranchMet),
      .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
      .LOout(LOout), .InPortout(InPortout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
      .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
      .IncPC(IncPC), .Read(Read), .Write(Write), .Cin(Cin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONIn(CONIn), .Strobe(Strobe),
      .Mdatain(Mdatain), .InPort_data(InPort_data), .SUB(SUB), .AND(AND), .ADD(ADD)
   );

   localparam logic [31:0] PCO = 32'd1 << 0,  ZHO = 32'd1 << 1,  ZLO = 32'd1 << 2,  MDRO = 32'd1 << 3;
   localparam logic [31:0] HIO = 32'd1 << 4,  LOO = 32'd1 << 5,  INPO = 32'd1 << 6, ROUT = 32'd1 << 7;
   localparam logic [31:0] BAO = 32'd1 << 8,  COUT = 32'd1 << 9, MARI = 32'd1 << 10, ZIN = 32'd1 << 11;
   localparam logic [31:0] PCI = 32'd1 << 12, MDRI = 32'd1 << 13, IRI = 32'd1 << 14, YIN = 32'd1 << 15;
   localparam logic [31:0] HII = 32'd1 << 16, LOI = 32'd1 << 17, OPI = 32'd1 << 18, INC = 32'd1 << 19;
   localparam logic [31:0] RD = 32'd1 << 20,  WR = 32'd1 << 21,  CIN = 32'd1 << 22, GRA = 32'd1 << 23;
   localparam logic [31:0] GRB = 32'd1 << 24, GRC = 32'd1 << 25, RIN = 32'd1 << 26, CONI = 32'd1 << 27;
   localparam logic [31:0] STB = 32'd1 << 28, OSUB = 32'd1 << 29, OAND = 32'd1 << 30, OADD = 32'd1 << 31;

   typedef struct { bit is_con; logic [31:0] val; } exp_t;
   exp_t exp_q[$];
   int   checks = 0, failures = 0;
   int   obs_id = 0, obs_cnt = 0, seen_id = 0;
   bit   force_exp = 0;
   logic [31:0] force_val;

   // Reference state: architectural registers as plain variables.
   logic [31:0] m_rf [16];
   logic [31:0] m_pc, m_ir, m_mdr, m_y, m_zlo, m_hi, m_lo, m_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit has(input logic [31:0] m, input logic [31:0] f);
      return (m & f) != 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
      m_pc = 0; m_ir = 0; m_mdr = 0; m_y = 0; m_zlo = 0; m_hi = 0; m_lo = 0; m_in = 0;
   endtask

   task automatic drive(input logic [31:0] m);
      {ADD, AND, SUB, Strobe, CONIn, Rin, Grc, Grb, Gra, Cin, Write, Read, IncPC,
       OutPortin, LOin, HIin, Yin, IRin, MDRin, PCin, Zin, MARin,
       Cout, BAout, Rout, InPortout, LOout, HIout, MDRout, Zlowout, Zhiout, PCout} = m;
   endtask

   task automatic do_cycle(input logic [31:0] m);
      logic [3:0]  sel;
      logic [31:0] bus, alu, c;
      logic        cond;
      int          n;
      drive(m);
      sel = (has(m, GRA) ? m_ir[26:23] : 4'd0) | (has(m, GRB) ? m_ir[22:19] : 4'd0)
          | (has(m, GRC) ? m_ir[18:15] : 4'd0);
      c = m_ir & 32'h7FFFF;
      if (m_ir[18]) c = c - 32'h80000;
      if      (has(m, PCO))  bus = m_pc;
      else if (has(m, ZHO))  bus = 0;
      else if (has(m, ZLO))  bus = m_zlo;
      else if (has(m, MDRO)) bus = m_mdr;
      else if (has(m, HIO))  bus = m_hi;
      else if (has(m, LOO))  bus = m_lo;
      else if (has(m, INPO)) bus = m_in;
      else if (has(m, ROUT) || has(m, BAO)) bus = (has(m, BAO) && sel == 0) ? 32'd0 : m_rf[sel];
      else if (has(m, COUT)) bus = c;
      else bus = 0;
      if      (has(m, INC))  alu = bus + 1;
      else if (has(m, OADD)) alu = m_y + bus + (has(m, CIN) ? 32'd1 : 32'd0);
      else if (has(m, OSUB)) alu = m_y - bus;
      else if (has(m, OAND)) alu = m_y & bus;
      else alu = bus;
      case (m_ir[20:19])
         2'd0: cond = (bus == 0);
         2'd1: cond = (bus != 0);
         2'd2: cond = (bus < 32'h80000000);
         default: cond = (bus >= 32'h80000000);
      endcase
      n = 0;
      if (has(m, OPI)) begin
         exp_q.push_back('{0, force_exp ? force_val : bus});
         force_exp = 0; n++;
      end
      if (has(m, CONI)) begin
         exp_q.push_back('{1, force_exp ? force_val : {31'd0, cond}});
         force_exp = 0; n++;
      end
      if (has(m, ZIN))  m_zlo = alu;
      if (has(m, PCI))  m_pc = bus;
      if (has(m, MDRI)) m_mdr = has(m, RD) ? Mdatain : bus;
      if (has(m, IRI))  m_ir = bus;
      if (has(m, YIN))  m_y = bus;
      if (has(m, HII))  m_hi = bus;
      if (has(m, LOI))  m_lo = bus;
      if (has(m, STB))  m_in = InPort_data;
      if (has(m, RIN))  m_rf[sel] = bus;
      @(posedge Clock);
      #1;
      if (n > 0) begin
         obs_cnt = n;
         obs_id++;
      end
      drive(0);
   endtask

   task automatic probe(input logic [31:0] m, input logic [31:0] k);
      force_exp = 1;
      force_val = k;
      do_cycle(m);
   endtask

   task automatic load_ir(input logic [31:0] v);
      Mdatain = v;
      do_cycle(RD | MDRI);
      do_cycle(MDRO | IRI);
   endtask

   exp_t e;
   always @(negedge Clock) begin
      if (obs_id != seen_id) begin
         seen_id = obs_id;
         repeat (obs_cnt) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               if (e.is_con) check("branch_met", {31'd0, BranchMet}, e.val);
               else          check("outp", outp, e.val);
            end
         end
      end
   end

   initial begin
      logic [31:0] m;
      model_reset();
      #12;
      check("reset_outp", outp, 32'd0);
      check("reset_branchmet", {31'd0, BranchMet}, 32'd0);
      @(posedge Clock); #1;
      Clear = 1;

      load_ir(32'h00800000);
      Mdatain = 32'd10;
      do_cycle(RD | MDRI);
      do_cycle(MDRO | GRA | RIN);
      probe(GRA | ROUT | OPI, 32'd10);

      do_cycle(PCO | MARI | INC | ZIN);
      do_cycle(ZLO | PCI);
      probe(PCO | OPI, 32'd1);

      load_ir(32'h590FFFFB);
      do_cycle(GRB | ROUT | YIN);
      do_cycle(COUT | OADD | ZIN);
      probe(ZLO | OPI, 32'd5);
      probe(ZHO | OPI, 32'd0);
      do_cycle(ZLO | GRA | RIN);
      probe(GRA | ROUT | OPI, 32'd5);

      load_ir(32'h00000000);
      probe(BAO | GRA | CONI, 32'd1);
      load_ir(32'h01180000);
      probe(BAO | GRA | CONI, 32'd0);

      load_ir(32'h00000000);
      Mdatain = 32'h00001234;
      do_cycle(RD | MDRI);
      do_cycle(MDRO | GRA | RIN);
      probe(GRA | ROUT | OPI, 32'h00001234);
      probe(GRA | BAO | OPI, 32'd0);

      InPort_data = 32'hDEADBEEF;
      do_cycle(STB);
      probe(INPO | OPI, 32'hDEADBEEF);

      Mdatain = 32'hFFFFFFFF;
      do_cycle(RD | MDRI);
      do_cycle(MDRO | YIN);
      do_cycle(PCO | OADD | ZIN);
      probe(ZLO | OPI, 32'd0);
      probe(PCO | MDRO | INPO | OPI, 32'd1);

      for (int i = 0; i < 400; i++) begin
         Mdatain = $urandom;
         InPort_data = $urandom;
         m = $urandom & $urandom & $urandom;
         if (has(m, ROUT) && has(m, BAO)) m = m & ~BAO;
         if ($urandom_range(0, 1) == 1) m = m | OPI;
         do_cycle(m);
      end

      load_ir(32'h00080055);
      probe(MDRO | OPI, 32'h00080055);
      probe(MDRO | CONI, 32'd1);
      @(posedge Clock); #3;
      Clear = 0;
      #1;
      check("clear_outp", outp, 32'd0);
      check("clear_branchmet", {31'd0, BranchMet}, 32'd0);
      model_reset();
      #2;
      Clear = 1;
      @(posedge Clock); #1;
      probe(PCO | OPI, 32'd0);
      probe(GRA | ROUT | OPI, 32'd0);
      probe(HIO | CONI, 32'd1);

      repeat (3) @(posedge Clock);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/datapath_p2.md
# datapath_p2

Single-bus 32-bit CPU datapath: a 16×32 register file, PC, IR, MAR, MDR, Y, 64-bit Z, HI/LO, in/out ports, a small ALU and the CON branch-condition flip-flop, all joined by one shared 32-bit bus. All control signals come from an external control unit; memory data arrives on `Mdatain`. Each register loads from the bus on a rising clock edge when its `*in` strobe is high.

## Interface
- No parameters. Data width is fixed at 32 bits, and the register file is fixed at 16 entries.
- `Clock` in 1: sole clock, rising edge.
- `Clear` in 1: asynchronous, active-low reset.
- `outp` out 32: OutPort register contents.
- `BranchMet` out 1: CON flip-flop.
- `PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout` in 1 each: bus source selects.
- `MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin` in 1 each: register load enables.
- `IncPC` in 1: ALU computes bus+1.
- `Read` in 1: MDR input mux selects `Mdatain`; when low, MDR takes the bus.
- `Write` in 1: memory write strobe. It has no internal effect.
- `Cin` in 1: carry-in added to ADD.
- `Gra, Grb, Grc` in 1 each: register-field select, taken from IR.
- `Rin, Rout` in 1 each: register-file write and drive.
- `BAout` in 1: register-file drive with R0 forced to 0.
- `Cout` in 1: drive the sign-extended constant.
- `CONIn` in 1: latch the branch condition.
- `Strobe` in 1: InPort capture.
- `Mdatain` in 32: memory read data.
- `InPort_data` in 32: external input port.
- `SUB, AND, ADD` in 1 each: ALU operation selects.

## Operation
- **Bus source priority** (first asserted wins): PC, Zhi, Zlo, MDR, HI, LO, InPort, register file (Rout/BAout), C.
  - With no source asserted, the bus is 0.
- **Register select**
  - Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - Selected index = (Gra·Ra) | (Grb·Rb) | (Grc·Rc).
- **Register file write:** with Rin high, the selected register is written from the bus.
- **Register file drive**
  - With Rout high, the selected register drives the bus.
  - With BAout high, the selected register also drives the bus, except that R0 reads as 0.
  - R0 remains writable.
- **Constant:** C = sign-extend(IR[18:0]) to 32 bits.
- **ALU:** A = Y, B = bus. The result is captured into Z on Zin.
  - Operation priority: IncPC (B+1), ADD (A+B+Cin), SUB (A−B), AND (A&B).
  - With no operation selected, the result is B.
  - Result width: Zlo = 32-bit result with wrap-around modulo 2^32; Zhi = 0.
- **MDR:** loads on MDRin from `Mdatain` when Read is high, otherwise from the bus.
- **CON flip-flop**
  - Condition code C2 = IR[20:19]: 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
  - BranchMet loads on CONIn.
- **InPort:** loads `InPort_data` on Strobe.
- **OutPort:** loads the bus on OutPortin and drives `outp`.

## Timing
- All state updates on the rising edge of Clock when the corresponding enable is high. With the enable low, the register holds.
- The bus, ALU, select/encode logic and C are combinational. Z holds an edge-sampled ALU result; a ZLo read sees the value from the previous Zin edge.
- When a register is both a bus source and a destination in the same cycle, the destination takes the pre-edge bus value.
- Clear low immediately zeroes every register: R0–R15, PC, IR, MAR, MDR, Y, Z (hi and lo), HI, LO, InPort, OutPort and CON. So `outp` = 0 and `BranchMet` = 0.
- Clear acts mid-sequence regardless of the clock. Release of Clear is synchronous-safe: the first load happens on the next rising edge.

## Structure
- Shared package: bus-source encoding, IR field positions (Ra/Rb/Rc/C2/C), ALU operation constants.
- Natural sub-module `reg32`: 32-bit register with load enable and async active-low clear, instantiated for all registers.
- Select/encode logic, ALU, bus mux and CON logic stay inline.

## Test plan
- **Register preload:** Mdatain=0x00800000, Read+MDRin, then MDRout+IRin; then Mdatain=10, Read+MDRin, then MDRout+Gra+Rin → R1=10.
- **Fetch:** PC=0. PCout+MARin+IncPC+Zin, then Zlowout+PCin → PC=1, MAR=0.
- **addi:**
  - Load IR=0x590FFFFB.
  - Grb+Rout+Yin → Y=10.
  - Cout+ADD+Zin → Zlo=5, Zhi=0.
  - Zlowout+Gra+Rin → R2=5.
- **Branch:**
  - IR C2=00 with R0 holding 0 → BAout+Gra+CONIn → BranchMet=1.
  - C2=11 with the bus at 5 → BranchMet=0.
- **I/O:** InPort_data=0xDEADBEEF with Strobe, then InPortout+OutPortin → outp=0xDEADBEEF.
- **Reset and wrap:**
  - Y=0xFFFFFFFF, ADD with bus=1 → Zlo=0.
  - Assert Clear mid-cycle → all outputs 0 immediately.
